// File: rtl/full_adder_unit_pkg.sv
// ----------------------------------------------------------------------------
// full_adder_unit_pkg
//
// Shared definitions for the full_adder_unit slice.
//   ADD_WIDTH_DEFAULT : default operand width of the adder (a plain full adder)
//   ADD_REF_MAX_W     : widest operand the reference function accepts
//   add_ref()         : reference result {co, s} = a + b + ci for a given
//                       width, for use by checkers and benches
// ----------------------------------------------------------------------------
package full_adder_unit_pkg;

    localparam int ADD_WIDTH_DEFAULT = 1;
    localparam int ADD_REF_MAX_W     = 64;

    // Returns {co, s} in bits [width:0]; higher bits are zero. Operands are
    // masked to 'width' bits first so stray upper bits cannot leak in.
    function automatic logic [ADD_REF_MAX_W:0] add_ref(
        input logic [ADD_REF_MAX_W-1:0] a,
        input logic [ADD_REF_MAX_W-1:0] b,
        input logic                     ci,
        input int unsigned              width
    );
        logic [ADD_REF_MAX_W:0] op_mask;
        logic [ADD_REF_MAX_W:0] res_mask;
        logic [ADD_REF_MAX_W:0] total;
        op_mask  = (({{ADD_REF_MAX_W{1'b0}}, 1'b1}) << width) - 1'b1;
        res_mask = (op_mask << 1) | 1'b1;
        total    = ({1'b0, a} & op_mask) + ({1'b0, b} & op_mask)
                 + {{ADD_REF_MAX_W{1'b0}}, ci};
        return total & res_mask;
    endfunction

endpackage

// File: rtl/full_adder_unit_if.sv
// ----------------------------------------------------------------------------
// full_adder_unit_if
//
// Operand/result bundle of the adder.
//   a, b   : unsigned operands, WIDTH bits
//   ci     : carry-in
//   s, co  : combinational sum / carry-out
//   s_q    : registered sum
//   co_q   : registered carry-out
// Modports:
//   master : drives operands, observes results (user of the adder)
//   slave  : receives operands, drives results (the adder itself)
// ----------------------------------------------------------------------------
interface full_adder_unit_if
    import full_adder_unit_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    modport master (
        output a, b, ci,
        input  s, co, s_q, co_q
    );

    modport slave (
        input  a, b, ci,
        output s, co, s_q, co_q
    );

endinterface

// File: rtl/full_adder_unit_fa_bit.sv
// ----------------------------------------------------------------------------
// fa_bit
//
// Single-bit full adder cell.
//   x, y : addend bits
//   cin  : carry in
//   sum  : x ^ y ^ cin
//   cout : majority(x, y, cin)
// ----------------------------------------------------------------------------
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/full_adder_unit.sv
// ----------------------------------------------------------------------------
// full_adder_unit
//
// WIDTH-bit ripple-carry adder built from fa_bit cells, with a registered
// copy of the result.
//   clk   : rising-edge clock, used only by s_q/co_q
//   rst_n : asynchronous active-low reset, clears s_q/co_q only
//   bus   : full_adder_unit_if slave port
//             a, b, ci -> s, co   (combinational, {co, s} = a + b + ci)
//             s_q, co_q           (s, co registered on clk)
// ----------------------------------------------------------------------------
module full_adder_unit
    import full_adder_unit_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    full_adder_unit_if.slave  bus
);

    // carry[i] feeds cell i; carry[WIDTH] is the final carry-out
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    assign carry[0] = bus.ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_bit u_fa_bit (
            .x    (bus.a[i]),
            .y    (bus.b[i]),
            .cin  (carry[i]),
            .sum  (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    assign bus.s  = sum_bits;
    assign bus.co = carry[WIDTH];

    // Result register; reset clears it immediately, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s_q  <= '0;
            bus.co_q <= 1'b0;
        end else begin
            bus.s_q  <= sum_bits;
            bus.co_q <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_full_adder_unit.sv
// ----------------------------------------------------------------------------
// tb_full_adder_unit
//
// Directed bench for full_adder_unit at WIDTH=1 and WIDTH=8. Expected values
// are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_full_adder_unit;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    full_adder_unit_if #(.WIDTH(1)) if1 ();
    full_adder_unit_if #(.WIDTH(8)) if8 ();

    full_adder_unit #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    full_adder_unit #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: never hang
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        if1.a = 1'b1; if1.b = 1'b0; if1.ci = 1'b1;
        if8.a = 8'h12; if8.b = 8'h34; if8.ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_q_w1: got %b, expected 00", {if1.co_q, if1.s_q});
        end
        n_vec++;
        if ({if8.co_q, if8.s_q} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_q_w8: got %h, expected 000", {if8.co_q, if8.s_q});
        end
        // combinational path is live during reset: 1+0+1 = 10
        n_vec++;
        if ({if1.co, if1.s} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_comb_w1: got %b, expected 10", {if1.co, if1.s});
        end
        // 0x12 + 0x34 = 0x46
        n_vec++;
        if ({if8.co, if8.s} !== 9'h046) begin
            n_err++;
            $display("FAIL reset_comb_w8: got %h, expected 046", {if8.co, if8.s});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [1:0] exp_tab [8];
        logic [2:0] vec;
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vec = 3'(i);
            if1.a = vec[2]; if1.b = vec[1]; if1.ci = vec[0];
            #1;
            n_vec++;
            if ({if1.co, if1.s} !== exp_tab[i]) begin
                n_err++;
                $display("FAIL truth_table[%b]: got %b, expected %b",
                         vec, {if1.co, if1.s}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_single_bit_cases();
        @(negedge clk);
        if1.a = 1'b1; if1.b = 1'b1; if1.ci = 1'b0;
        #1;
        n_vec++;
        if ({if1.co, if1.s} !== 2'b10) begin
            n_err++;
            $display("FAIL single_110: got %b, expected 10", {if1.co, if1.s});
        end
        if1.a = 1'b0; if1.b = 1'b0; if1.ci = 1'b1;
        #1;
        n_vec++;
        if ({if1.co, if1.s} !== 2'b01) begin
            n_err++;
            $display("FAIL single_001: got %b, expected 01", {if1.co, if1.s});
        end
    endtask

    task automatic test_wide_ripple();
        logic [7:0] va   [4];
        logic [7:0] vb   [4];
        logic       vci  [4];
        logic [8:0] vexp [4];
        va   = '{8'hFF, 8'hFF, 8'h0F, 8'hA5};
        vb   = '{8'h00, 8'hFF, 8'h01, 8'h5A};
        vci  = '{1'b1,  1'b1,  1'b0,  1'b0};
        vexp = '{9'h100, 9'h1FF, 9'h010, 9'h0FF};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if8.a = va[i]; if8.b = vb[i]; if8.ci = vci[i];
            #1;
            n_vec++;
            if ({if8.co, if8.s} !== vexp[i]) begin
                n_err++;
                $display("FAIL wide_comb[%0d]: got %h, expected %h",
                         i, {if8.co, if8.s}, vexp[i]);
            end
        end
    endtask

    // Consecutive operands on every cycle; each registered result must be
    // the one sampled at the most recent edge.
    task automatic test_back_to_back();
        logic [7:0] va   [3];
        logic [7:0] vb   [3];
        logic       vci  [3];
        logic [8:0] vexp [3];
        va   = '{8'h80, 8'h01, 8'hFE};
        vb   = '{8'h80, 8'h02, 8'h01};
        vci  = '{1'b0,  1'b1,  1'b1};
        vexp = '{9'h100, 9'h004, 9'h100};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if8.a = va[i]; if8.b = vb[i]; if8.ci = vci[i];
            @(posedge clk);
            #1;
            n_vec++;
            if ({if8.co_q, if8.s_q} !== vexp[i]) begin
                n_err++;
                $display("FAIL back_to_back_q[%0d]: got %h, expected %h",
                         i, {if8.co_q, if8.s_q}, vexp[i]);
            end
        end
    endtask

    task automatic test_registered_latency();
        @(negedge clk);
        if1.a = 1'b0; if1.b = 1'b0; if1.ci = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b00) begin
            n_err++;
            $display("FAIL latency_pre: got %b, expected 00", {if1.co_q, if1.s_q});
        end
        @(negedge clk);
        if1.a = 1'b1; if1.b = 1'b1; if1.ci = 1'b1;
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b00) begin
            n_err++;
            $display("FAIL latency_hold: got %b, expected 00", {if1.co_q, if1.s_q});
        end
        n_vec++;
        if ({if1.co, if1.s} !== 2'b11) begin
            n_err++;
            $display("FAIL latency_comb: got %b, expected 11", {if1.co, if1.s});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b11) begin
            n_err++;
            $display("FAIL latency_load: got %b, expected 11", {if1.co_q, if1.s_q});
        end
    endtask

    task automatic test_async_reset();
        // s_q=1, co_q=1 held from the previous task; drop reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b00) begin
            n_err++;
            $display("FAIL async_clear_w1: got %b, expected 00", {if1.co_q, if1.s_q});
        end
        n_vec++;
        if ({if8.co_q, if8.s_q} !== 9'h000) begin
            n_err++;
            $display("FAIL async_clear_w8: got %h, expected 000", {if8.co_q, if8.s_q});
        end
        n_vec++;
        if ({if1.co, if1.s} !== 2'b11) begin
            n_err++;
            $display("FAIL async_comb_hold: got %b, expected 11", {if1.co, if1.s});
        end
        if1.a = 1'b0; if1.b = 1'b1; if1.ci = 1'b0;
        #1;
        n_vec++;
        if ({if1.co, if1.s} !== 2'b01) begin
            n_err++;
            $display("FAIL async_comb_track: got %b, expected 01", {if1.co, if1.s});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b00) begin
            n_err++;
            $display("FAIL async_hold_in_reset: got %b, expected 00", {if1.co_q, if1.s_q});
        end
    endtask

    task automatic test_reset_release();
        @(negedge clk);
        if1.a = 1'b1; if1.b = 1'b0; if1.ci = 1'b0;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b00) begin
            n_err++;
            $display("FAIL release_pre_edge: got %b, expected 00", {if1.co_q, if1.s_q});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({if1.co_q, if1.s_q} !== 2'b01) begin
            n_err++;
            $display("FAIL release_first_edge: got %b, expected 01", {if1.co_q, if1.s_q});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if1.a = '0; if1.b = '0; if1.ci = 1'b0;
        if8.a = '0; if8.b = '0; if8.ci = 1'b0;

        test_reset();
        test_truth_table();
        test_single_bit_cases();
        test_wide_ripple();
        test_back_to_back();
        test_registered_latency();
        test_async_reset();
        test_reset_release();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
